// File: rtl/ram_io_responder.sv
// Byte-wide memory responder: RAM with 1-cycle registered read plus an IO window
// at mem_a[17:16]==2'b11 holding the UART TX/RX FIFOs, status and sim-end registers.
module ram_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 8,
    parameter int RX_DEPTH   = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [31:0]           mem_a,
    input  logic                  mem_wr,
    input  logic [7:0]            mem_dout,
    output logic [7:0]            mem_din,
    output logic                  io_buffer_full,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [7:0]            prog_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  sim_end,
    output logic [7:0]            sim_end_code,
    output logic                  tx_overflow
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);

    logic [7:0] ram_q [0:(1<<ADDR_WIDTH)-1];
    logic [7:0] tx_mem_q [0:TX_DEPTH-1];
    logic [7:0] rx_mem_q [0:RX_DEPTH-1];

    logic [TX_AW:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d, tx_count_q, tx_count_d;
    logic [RX_AW:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d, rx_count_q, rx_count_d;

    logic [7:0] mem_din_q, mem_din_d;
    logic       sim_end_q, sim_end_d;
    logic [7:0] sim_end_code_q, sim_end_code_d;
    logic       tx_overflow_q, tx_overflow_d;

    logic [ADDR_WIDTH-1:0] idx;
    logic is_io, sel_data, sel_ctrl;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic ram_wr;
    logic unused_addr;

    assign idx         = mem_a[ADDR_WIDTH-1:0];
    assign is_io       = (mem_a[17:16] == 2'b11);
    assign sel_data    = is_io && (mem_a[15:3] == 13'd0) && !mem_a[2];
    assign sel_ctrl    = is_io && (mem_a[15:3] == 13'd0) &&  mem_a[2];
    assign unused_addr = ^{mem_a[31:18], mem_a[1:0]};

    assign tx_full  = (tx_count_q == TX_FULL_CNT);
    assign tx_empty = (tx_count_q == '0);
    assign rx_full  = (rx_count_q == RX_FULL_CNT);
    assign rx_empty = (rx_count_q == '0);

    // Full tests use the pre-cycle count, so a push into a full FIFO is dropped
    // even when the other side pops in the same cycle.
    assign tx_push = mem_wr && sel_data && !tx_full;
    assign tx_pop  = !tx_empty && tx_ready;
    assign rx_push = rx_valid && !rx_full;
    assign rx_pop  = !mem_wr && sel_data && !rx_empty;
    assign ram_wr  = mem_wr && !is_io && !prog_we;

    assign mem_din        = mem_din_q;
    assign io_buffer_full = tx_full;
    assign tx_valid       = !tx_empty;
    assign tx_data        = tx_mem_q[tx_rd_ptr_q[TX_AW-1:0]];
    assign rx_ready       = !rx_full;
    assign sim_end        = sim_end_q;
    assign sim_end_code   = sim_end_code_q;
    assign tx_overflow    = tx_overflow_q;

    always_comb begin
        mem_din_d = 8'h00;
        if (!mem_wr) begin
            if (!is_io) begin
                mem_din_d = ram_q[idx];
            end else if (sel_data) begin
                mem_din_d = rx_empty ? 8'h00 : rx_mem_q[rx_rd_ptr_q[RX_AW-1:0]];
            end else if (sel_ctrl) begin
                mem_din_d = {6'b0, tx_full, !rx_empty};
            end
        end
    end

    always_comb begin
        tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + 1'b1 : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + 1'b1 : tx_rd_ptr_q;
        tx_count_d  = tx_count_q;
        if (tx_push && !tx_pop) begin
            tx_count_d = tx_count_q + 1'b1;
        end else if (!tx_push && tx_pop) begin
            tx_count_d = tx_count_q - 1'b1;
        end
    end

    always_comb begin
        rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + 1'b1 : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + 1'b1 : rx_rd_ptr_q;
        rx_count_d  = rx_count_q;
        if (rx_push && !rx_pop) begin
            rx_count_d = rx_count_q + 1'b1;
        end else if (!rx_push && rx_pop) begin
            rx_count_d = rx_count_q - 1'b1;
        end
    end

    always_comb begin
        sim_end_d      = mem_wr && sel_ctrl;
        sim_end_code_d = sim_end_d ? mem_dout : sim_end_code_q;
        tx_overflow_d  = tx_overflow_q || (mem_wr && sel_data && tx_full);
    end

    // RAM is never cleared by reset; host preload wins over a bus write.
    always_ff @(posedge clk_in) begin
        if (prog_we) begin
            ram_q[prog_addr] <= prog_data;
        end else if (ram_wr) begin
            ram_q[idx] <= mem_dout;
        end
    end

    always_ff @(posedge clk_in) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_ptr_q[TX_AW-1:0]] <= mem_dout;
        end
        if (rx_push) begin
            rx_mem_q[rx_wr_ptr_q[RX_AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_din_q      <= 8'h00;
            tx_wr_ptr_q    <= '0;
            tx_rd_ptr_q    <= '0;
            tx_count_q     <= '0;
            rx_wr_ptr_q    <= '0;
            rx_rd_ptr_q    <= '0;
            rx_count_q     <= '0;
            sim_end_q      <= 1'b0;
            sim_end_code_q <= 8'h00;
            tx_overflow_q  <= 1'b0;
        end else begin
            mem_din_q      <= mem_din_d;
            tx_wr_ptr_q    <= tx_wr_ptr_d;
            tx_rd_ptr_q    <= tx_rd_ptr_d;
            tx_count_q     <= tx_count_d;
            rx_wr_ptr_q    <= rx_wr_ptr_d;
            rx_rd_ptr_q    <= rx_rd_ptr_d;
            rx_count_q     <= rx_count_d;
            sim_end_q      <= sim_end_d;
            sim_end_code_q <= sim_end_code_d;
            tx_overflow_q  <= tx_overflow_d;
        end
    end

endmodule

// File: tb/tb_ram_io_responder.sv
// Bench for ram_io_responder: queue/array reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ram_io_responder;

    localparam int TXD = 8;
    localparam int RXD = 8;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] mem_a = 32'h0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_dout = 8'h0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        prog_we = 1'b0;
    logic [16:0] prog_addr = 17'h0;
    logic [7:0]  prog_data = 8'h0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        sim_end;
    logic [7:0]  sim_end_code;
    logic        tx_overflow;

    always #5 clk = ~clk;

    ram_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk_in(clk), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
        .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .sim_end(sim_end), .sim_end_code(sim_end_code), .tx_overflow(tx_overflow)
    );

    // Reference model state
    logic [7:0] ram_m [0:131071];
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] m_din = 8'h0;
    logic       m_send = 1'b0;
    logic [7:0] m_code = 8'h0;
    logic       m_ovf = 1'b0;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] IDLE_A = 32'h0000_3FF0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock: update model from the pre-edge state and inputs, then compare.
    task automatic step();
        logic io, dsel, csel, txfull, rxne, txpush, rxpush;
        logic [7:0] nd;
        io   = (mem_a[17:16] == 2'b11);
        dsel = io && (mem_a[15:3] == 13'd0) && !mem_a[2];
        csel = io && (mem_a[15:3] == 13'd0) &&  mem_a[2];
        if (rst_in) begin
            txq.delete();
            rxq.delete();
            m_din = 8'h0; m_send = 1'b0; m_code = 8'h0; m_ovf = 1'b0;
        end else begin
            txfull = (txq.size() == TXD);
            rxne   = (rxq.size() != 0);
            rxpush = rx_valid && (rxq.size() < RXD);
            txpush = 1'b0;
            nd     = 8'h0;
            if (!mem_wr) begin
                if (!io) nd = ram_m[mem_a[16:0]];
                else if (dsel) begin
                    if (rxne) nd = rxq.pop_front();
                end else if (csel) nd = {6'b0, txfull, rxne};
            end else if (dsel) begin
                if (txfull) m_ovf = 1'b1;
                else txpush = 1'b1;
            end
            m_send = mem_wr && csel;
            if (m_send) m_code = mem_dout;
            if (txq.size() != 0 && tx_ready) void'(txq.pop_front());
            if (txpush) txq.push_back(mem_dout);
            if (rxpush) rxq.push_back(rx_data);
            m_din = nd;
        end
        if (prog_we) ram_m[prog_addr] = prog_data;
        else if (mem_wr && !io) ram_m[mem_a[16:0]] = mem_dout;

        @(posedge clk);
        #1;
        chk("mem_din", mem_din, m_din);
        chk("tx_valid", tx_valid, (txq.size() != 0));
        if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
        chk("io_buffer_full", io_buffer_full, (txq.size() == TXD));
        chk("rx_ready", rx_ready, (rxq.size() < RXD));
        chk("sim_end", sim_end, m_send);
        chk("sim_end_code", sim_end_code, m_code);
        chk("tx_overflow", tx_overflow, m_ovf);
    endtask

    task automatic idle();
        mem_a = IDLE_A; mem_wr = 1'b0; prog_we = 1'b0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
        mem_a = a; mem_wr = 1'b1; mem_dout = d;
        step();
        idle();
    endtask

    task automatic bus_rd(input logic [31:0] a);
        mem_a = a; mem_wr = 1'b0;
        step();
        idle();
    endtask

    initial begin
        // Reset, preloading the idle read address so idle reads are defined
        idle();
        rst_in = 1'b1;
        prog_we = 1'b1; prog_addr = IDLE_A[16:0]; prog_data = 8'h5C;
        step();
        prog_we = 1'b0;
        step();
        chk("reset_mem_din", mem_din, 8'h00);
        chk("reset_tx_valid", tx_valid, 1'b0);
        chk("reset_rx_ready", rx_ready, 1'b1);
        chk("reset_full", io_buffer_full, 1'b0);
        chk("reset_sim_end", sim_end, 1'b0);
        chk("reset_code", sim_end_code, 8'h00);
        chk("reset_ovf", tx_overflow, 1'b0);
        rst_in = 1'b0;
        step();
        chk("idle_read", mem_din, 8'h5C);

        // 1: preload and back-to-back readback
        for (int i = 0; i < 4; i++) begin
            prog_we = 1'b1; prog_addr = 17'(i); prog_data = 8'(8'h11 * (i + 1));
            step();
        end
        prog_we = 1'b0;
        bus_rd(32'h0); chk("t1_rd0", mem_din, 8'h11);
        bus_rd(32'h1); chk("t1_rd1", mem_din, 8'h22);
        bus_rd(32'h2); chk("t1_rd2", mem_din, 8'h33);
        bus_rd(32'h3); chk("t1_rd3", mem_din, 8'h44);

        // 2: write then read, and prog_we priority
        bus_wr(32'h100, 8'hA5);
        chk("t2_wr_din", mem_din, 8'h00);
        bus_rd(32'h100); chk("t2_rd", mem_din, 8'hA5);
        prog_we = 1'b1; prog_addr = 17'h100; prog_data = 8'h5A;
        bus_wr(32'h100, 8'h33);
        bus_rd(32'h100); chk("t2_prog_wins", mem_din, 8'h5A);
        bus_wr(32'h100, 8'hA5);

        // 3: TX fill, overflow, drain
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus_wr(32'h30000, 8'(8'h80 + i));
            if (i == 7) chk("t3_full_after8", io_buffer_full, 1'b1);
        end
        chk("t3_ovf", tx_overflow, 1'b1);
        chk("t3_head", tx_data, 8'h80);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t3_drain", tx_data, 8'(8'h80 + i));
            step();
            if (i == 0) chk("t3_full_fall", io_buffer_full, 1'b0);
        end
        chk("t3_empty", tx_valid, 1'b0);

        // 4: RX path and status
        rx_valid = 1'b1; rx_data = 8'h41; step();
        rx_data = 8'h42; step();
        rx_valid = 1'b0;
        bus_rd(32'h30004); chk("t4_stat_ne", mem_din, 8'h01);
        bus_rd(32'h30000); chk("t4_rx0", mem_din, 8'h41);
        bus_rd(32'h30000); chk("t4_rx1", mem_din, 8'h42);
        bus_rd(32'h30000); chk("t4_rx_empty", mem_din, 8'h00);
        bus_rd(32'h30004); chk("t4_stat_e", mem_din, 8'h00);
        bus_rd(32'h30010); chk("t4_other_io", mem_din, 8'h00);

        // 5: sim_end pulse
        bus_wr(32'h30004, 8'h07);
        chk("t5_pulse", sim_end, 1'b1);
        chk("t5_code", sim_end_code, 8'h07);
        step();
        chk("t5_pulse_end", sim_end, 1'b0);
        chk("t5_code_hold", sim_end_code, 8'h07);

        // 6: reset mid-traffic
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_wr(32'h30000, 8'(8'hC0 + i));
        chk("t6_queued", tx_valid, 1'b1);
        mem_a = 32'h100; mem_wr = 1'b0; rst_in = 1'b1;
        step();
        chk("t6_tx_valid", tx_valid, 1'b0);
        chk("t6_mem_din", mem_din, 8'h00);
        rst_in = 1'b0;
        idle();
        bus_rd(32'h100); chk("t6_ram_kept", mem_din, 8'hA5);

        // Randomized traffic over a preloaded RAM window
        for (int i = 0; i < 64; i++) begin
            prog_we = 1'b1; prog_addr = 17'(i); prog_data = 8'($urandom);
            step();
        end
        idle();
        for (int n = 0; n < 1500; n++) begin
            int unsigned r;
            logic [31:0] hi;
            r  = $urandom_range(0, 9);
            hi = $urandom() & 32'hFFFC_0000;
            rst_in   = ($urandom_range(0, 149) == 0);
            tx_ready = ($urandom_range(0, 2) != 0);
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data  = 8'($urandom);
            mem_dout = 8'($urandom);
            mem_wr   = $urandom_range(0, 1) == 1;
            prog_we  = ($urandom_range(0, 7) == 0);
            prog_addr = 17'($urandom_range(0, 63));
            prog_data = 8'($urandom);
            if (r < 5 || txq.size() == TXD) mem_a = hi | 32'($urandom_range(0, 63));
            else if (r < 8) mem_a = hi | 32'h30000 | 32'($urandom_range(0, 3));
            else if (r < 9) mem_a = hi | 32'h30004;
            else mem_a = hi | 32'h30010;
            if (rst_in) begin
                mem_wr = 1'b0; prog_we = 1'b0;
            end
            step();
        end
        rst_in = 1'b0;
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
